// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared screen geometry and object constants for the pong design. The
//   motion controller and the pixel generator both import this package, so
//   every object size and start position comes from one place.
//   Also holds the single-bit motion direction type used by the ball logic.
package pong_pkg;

  localparam logic [9:0] MAX_X       = 10'd640;
  localparam logic [9:0] MAX_Y       = 10'd480;
  localparam logic [9:0] WALL_X_R    = 10'd35;
  localparam logic [9:0] BAR_X_L     = 10'd600;
  localparam logic [9:0] BAR_X_R     = 10'd603;
  localparam logic [9:0] BAR_Y_SIZE  = 10'd72;
  localparam logic [9:0] BAR_Y_INIT  = 10'd204;
  localparam logic [9:0] BALL_SIZE   = 10'd8;
  localparam logic [9:0] BALL_X_INIT = 10'd550;
  localparam logic [9:0] BALL_Y_INIT = 10'd240;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/pong_bar_ctrl.sv
// pong_bar_ctrl
//   Holds the bar's top row and moves it by BAR_V once per frame tick,
//   clamping at the top and bottom of the visible area.
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset (bar returns to BAR_Y_INIT)
//   refr_tick in   one-clk frame pulse; the only cycle the bar may move
//   btn       in   btn[1]=up, btn[0]=down; 00/11 hold
//   bar_y_t   out  registered bar top row
module pong_bar_ctrl
  import pong_pkg::*;
#(
  parameter logic [9:0] BAR_V = 10'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  output logic [9:0] bar_y_t
);

  logic [9:0] bar_next;

  // Guards are checked before the add/subtract so the 10-bit value never wraps.
  always_comb begin
    bar_next = bar_y_t;
    case (btn)
      2'b10: bar_next = (bar_y_t >= BAR_V) ? bar_y_t - BAR_V : 10'd0;
      2'b01: bar_next = (bar_y_t + BAR_Y_SIZE + BAR_V <= MAX_Y) ?
                        bar_y_t + BAR_V : MAX_Y - BAR_Y_SIZE;
      default: bar_next = bar_y_t;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_y_t <= BAR_Y_INIT;
    end else if (refr_tick) begin
      bar_y_t <= bar_next;
    end
  end

endmodule

// File: rtl/pong_motion_ctrl.sv
// pong_motion_ctrl
//   Frame-rate motion controller: on every refr_tick it moves the bar from the
//   buttons and moves the ball, reflecting it off the left wall, the top and
//   bottom edges and the bar. A ball that passes the right edge restarts.
// Ports
//   clk       in   system clock (only clock)
//   rst       in   synchronous active-high reset, wins over refr_tick
//   refr_tick in   one-clk frame pulse from vga_sync
//   btn       in   btn[1]=up, btn[0]=down
//   bar_y_t   out  bar top row (bar spans bar_y_t..bar_y_t+71)
//   ball_x_l  out  ball left column (ball is 8x8)
//   ball_y_t  out  ball top row
//   hit       out  one-clk pulse when the ball reflects off the bar
//   miss      out  one-clk pulse when the ball leaves the right edge
module pong_motion_ctrl
  import pong_pkg::*;
#(
  parameter logic [9:0] BAR_V  = 10'd4,
  parameter logic [9:0] BALL_V = 10'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_y_t,
  output logic       hit,
  output logic       miss
);

  dir_t       dir_x, dir_y;
  dir_t       dir_x_next, dir_y_next;
  logic [9:0] x_next, y_next;
  logic [9:0] ball_x_r, ball_y_b;
  logic       hit_next, miss_next;

  pong_bar_ctrl #(.BAR_V(BAR_V)) u_bar (
    .clk       (clk),
    .rst       (rst),
    .refr_tick (refr_tick),
    .btn       (btn),
    .bar_y_t   (bar_y_t)
  );

  // All tests look at the current ball position and the pre-update bar, so a
  // corner can flip both axes and the bar's own move this tick is not seen.
  always_comb begin
    ball_x_r   = ball_x_l + (BALL_SIZE - 10'd1);
    ball_y_b   = ball_y_t + (BALL_SIZE - 10'd1);
    dir_x_next = dir_x;
    dir_y_next = dir_y;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
    x_next     = ball_x_l;
    y_next     = ball_y_t;

    if (ball_y_t <= BALL_V) begin
      dir_y_next = DIR_POS;
    end else if (ball_y_t + BALL_SIZE + BALL_V >= MAX_Y) begin
      dir_y_next = DIR_NEG;
    end

    if (ball_x_l <= WALL_X_R + BALL_V) begin
      dir_x_next = DIR_POS;
    end

    if (ball_x_r >= BAR_X_L && ball_x_r <= BAR_X_R &&
        ball_y_b >= bar_y_t && ball_y_t <= bar_y_t + BAR_Y_SIZE - 10'd1 &&
        dir_x == DIR_POS) begin
      dir_x_next = DIR_NEG;
      hit_next   = 1'b1;
    end

    // A miss restarts the ball heading back toward the wall instead of moving.
    if (ball_x_r >= MAX_X - 10'd1) begin
      dir_x_next = DIR_NEG;
      dir_y_next = DIR_POS;
      x_next     = BALL_X_INIT;
      y_next     = BALL_Y_INIT;
      miss_next  = 1'b1;
    end else begin
      x_next = (dir_x_next == DIR_POS) ? ball_x_l + BALL_V : ball_x_l - BALL_V;
      y_next = (dir_y_next == DIR_POS) ? ball_y_t + BALL_V : ball_y_t - BALL_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x_l <= BALL_X_INIT;
      ball_y_t <= BALL_Y_INIT;
      dir_x    <= DIR_POS;
      dir_y    <= DIR_POS;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hit  <= refr_tick & hit_next;
      miss <= refr_tick & miss_next;
      if (refr_tick) begin
        ball_x_l <= x_next;
        ball_y_t <= y_next;
        dir_x    <= dir_x_next;
        dir_y    <= dir_y_next;
      end
    end
  end

endmodule
